btn_event_queue: RTL

- Consumes the 8-bit debounced button vector and converts level changes into discrete key events.
- Generates one press event per rising edge, plus auto-repeat events while a button is held.
- Buffers events in a small FIFO and hands them to the puzzle game FSM over a valid/ready handshake.
- Sits directly downstream of the debouncer and upstream of the game/move logic that drives the LED matrix.

---
 rtl/btn_event_queue_if.sv | 12 +
 rtl/btn_event_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/btn_event_queue_if.sv
// Key event handshake between the button event queue (master) and its consumer (slave).
interface btn_event_queue_if #(
  parameter int unsigned CODE_W = 3
);
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W-1:0] ev_code;
  logic              ev_repeat;

  modport master (output ev_valid, output ev_code, output ev_repeat, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_repeat, output ev_ready);
endinterface

// File: rtl/btn_event_queue.sv
// Turns debounced button levels into press / auto-repeat events, queued in a small FIFO
// and handed out over a valid/ready handshake.
module btn_event_queue #(
  parameter int unsigned N_BTN         = 8,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_BTN-1:0]                    btn_clean,
  btn_event_queue_if.master                   ev,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow
);

  localparam int unsigned CodeW  = $clog2(N_BTN);
  localparam int unsigned CntBW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned MaxCyc = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [1:0] {StIdle, StHoldWait, StRepeat} state_e;

  typedef struct packed {
    logic             rep;
    logic [CodeW-1:0] code;
  } entry_t;

  logic [N_BTN-1:0] prev_q, pending_q, pending_d, rise;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [CodeW-1:0] tgt_q, tgt_d, win_idx;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rep_flag_q, rep_flag_d;
  entry_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntBW-1:0] count_q, count_d;

  logic   pend_any, pop, full, can_push, push_press, push_rep, push, fire;
  entry_t push_entry;

  // Lowest pending index wins arbitration.
  always_comb begin
    win_idx = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (pending_q[i]) win_idx = CodeW'(i);
    end
  end

  always_comb begin
    rise       = btn_clean & ~prev_q;
    pend_any   = |pending_q;
    pop        = (count_q != '0) & ev.ev_ready;
    full       = (count_q == CntBW'(FIFO_DEPTH));
    can_push   = !full || pop;
    push_press = pend_any & can_push;
    push_rep   = !pend_any & rep_flag_q & can_push;
    push       = push_press | push_rep;
    push_entry = push_press ? '{rep: 1'b0, code: win_idx} : '{rep: 1'b1, code: tgt_q};

    pending_d = pending_q;
    if (push_press) pending_d[win_idx] = 1'b0;
    pending_d = pending_d | rise;

    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    rep_flag_d = rep_flag_q & ~push_rep;
    fire       = 1'b0;
    if (push_press) begin
      // Newest press always retargets the tracker.
      tgt_d      = win_idx;
      cnt_d      = '0;
      state_d    = StHoldWait;
      rep_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHoldWait: begin
          if (!btn_clean[tgt_q]) begin
            state_d    = StIdle;
            rep_flag_d = 1'b0;
          end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (!btn_clean[tgt_q]) begin
            state_d    = StIdle;
            rep_flag_d = 1'b0;
          end else if (cnt_q == CntW'(REPEAT_CYCLES - 1)) begin
            fire  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (fire) rep_flag_d = 1'b1;

    // A repeat is lost only if the previous one is still unqueued at the moment it fires.
    ovf_d = ovf_q | (|(rise & pending_q)) | (fire & rep_flag_q & ~push_rep);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '1;
      pending_q  <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      tgt_q      <= '0;
      cnt_q      <= '0;
      rep_flag_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      prev_q     <= btn_clean;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      rep_flag_q <= rep_flag_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign ev.ev_valid  = (count_q != '0);
  assign ev.ev_code   = mem_q[rd_ptr_q].code;
  assign ev.ev_repeat = mem_q[rd_ptr_q].rep;
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;

endmodule
